// File: rtl/wb_regfile_scoreboard.sv
// Write-back register file (16 x 24 by default) with per-register pending-write scoreboard.
// Optional feature: define WB_BYPASS_EN to forward same-cycle write-back data and release hazards.
module wb_regfile_scoreboard #(
  parameter int DATA_WIDTH   = 24,
  parameter int ADDR_WIDTH   = 4,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic                  issue_writes,
  input  logic [ADDR_WIDTH-1:0] issue_dest,
  input  logic [ADDR_WIDTH-1:0] issue_src_a,
  input  logic [ADDR_WIDTH-1:0] issue_src_b,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  input  logic                  wb_enable,
  input  logic [ADDR_WIDTH-1:0] wb_dest,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  sb_error
);

  localparam int NREG  = 2 ** ADDR_WIDTH;
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  logic [DATA_WIDTH-1:0] r_regs [NREG];
  logic [CNT_W-1:0]      r_pend [NREG];
  logic                  r_sb_error;

  logic w_wb_hit;
  logic w_haz_a;
  logic w_haz_b;
  logic w_dest_full;
  logic w_stall;
  logic w_inc;

  assign w_wb_hit = wb_enable && (wb_dest != '0);

  always_comb begin
    w_haz_a = (issue_src_a != '0) && (r_pend[issue_src_a] != '0);
    w_haz_b = (issue_src_b != '0) && (r_pend[issue_src_b] != '0);
`ifdef WB_BYPASS_EN
    // The last outstanding write landing this cycle satisfies the operand via the bypass.
    if (w_wb_hit && (wb_dest == issue_src_a) && (r_pend[issue_src_a] == ONE_CNT))
      w_haz_a = 1'b0;
    if (w_wb_hit && (wb_dest == issue_src_b) && (r_pend[issue_src_b] == ONE_CNT))
      w_haz_b = 1'b0;
`endif
    w_dest_full = issue_writes && (issue_dest != '0) && (r_pend[issue_dest] == MAX_CNT);
    w_stall     = issue_valid && (w_haz_a || w_haz_b || w_dest_full);
    w_inc       = issue_valid && !w_stall && issue_writes && (issue_dest != '0);
  end

  always_comb begin
    rd_data_a = (issue_src_a == '0) ? '0 : r_regs[issue_src_a];
    rd_data_b = (issue_src_b == '0) ? '0 : r_regs[issue_src_b];
`ifdef WB_BYPASS_EN
    if (w_wb_hit && (wb_dest == issue_src_a)) rd_data_a = wb_data;
    if (w_wb_hit && (wb_dest == issue_src_b)) rd_data_b = wb_data;
`endif
  end

  assign stall    = w_stall;
  assign sb_error = r_sb_error;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
        r_pend[i] <= '0;
      end
      r_sb_error <= 1'b0;
    end else begin
      if (w_wb_hit) begin
        r_regs[wb_dest] <= wb_data;
        if (r_pend[wb_dest] == '0) r_sb_error <= 1'b1;
      end
      // Register 0 is never counted; an issue and write-back to the same register cancel out.
      for (int i = 1; i < NREG; i++) begin
        if (w_inc && (issue_dest == ADDR_WIDTH'(i))) begin
          if (!(w_wb_hit && (wb_dest == ADDR_WIDTH'(i))))
            r_pend[i] <= r_pend[i] + ONE_CNT;
        end else if (w_wb_hit && (wb_dest == ADDR_WIDTH'(i)) && (r_pend[i] != '0)) begin
          r_pend[i] <= r_pend[i] - ONE_CNT;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Scoreboard bench for wb_regfile_scoreboard; expectations adapt to WB_BYPASS_EN.
module tb_wb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_writes;
  logic [3:0]  issue_dest, issue_src_a, issue_src_b;
  logic        stall;
  logic [23:0] rd_data_a, rd_data_b;
  logic        wb_enable;
  logic [3:0]  wb_dest;
  logic [23:0] wb_data;
  logic        sb_error;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic        stall;
    logic [23:0] a;
    logic [23:0] b;
    logic        err;
  } exp_t;

  exp_t sb_q[$];

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  wb_regfile_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_writes (issue_writes),
    .issue_dest   (issue_dest),
    .issue_src_a  (issue_src_a),
    .issue_src_b  (issue_src_b),
    .stall        (stall),
    .rd_data_a    (rd_data_a),
    .rd_data_b    (rd_data_b),
    .wb_enable    (wb_enable),
    .wb_dest      (wb_dest),
    .wb_data      (wb_data),
    .sb_error     (sb_error)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_issue(input logic v, input logic w, input logic [3:0] d,
                           input logic [3:0] a, input logic [3:0] b);
    issue_valid  = v;
    issue_writes = w;
    issue_dest   = d;
    issue_src_a  = a;
    issue_src_b  = b;
  endtask

  task automatic set_wb(input logic e, input logic [3:0] d, input logic [23:0] data);
    wb_enable = e;
    wb_dest   = d;
    wb_data   = data;
  endtask

  // Push expected outputs for the inputs just driven, sample mid-cycle, then advance one edge.
  task automatic step(input string tag, input logic es, input logic [23:0] ea,
                      input logic [23:0] eb, input logic ee);
    exp_t e;
    exp_t g;
    e.tag = tag; e.stall = es; e.a = ea; e.b = eb; e.err = ee;
    sb_q.push_back(e);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check_val({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      g = sb_q.pop_front();
      check_val({g.tag, ".stall"}, 32'(stall),     32'(g.stall));
      check_val({g.tag, ".rd_a"},  32'(rd_data_a), 32'(g.a));
      check_val({g.tag, ".rd_b"},  32'(rd_data_b), 32'(g.b));
      check_val({g.tag, ".err"},   32'(sb_error),  32'(g.err));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset edge with a competing issue and write-back that must both be discarded.
    rst = 1'b1;
    set_issue(1'b1, 1'b1, 4'd3, 4'd0, 4'd0);
    set_wb(1'b1, 4'd3, 24'h000055);
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_wb(1'b0, 4'd0, 24'h0);

    set_issue(1'b1, 1'b0, 4'd0, 4'd3, 4'd0);
    step("reset", 1'b0, 24'h0, 24'h0, 1'b0);

    // Producer to R1 at t, consumer waits for write-back at t+3.
    set_issue(1'b1, 1'b1, 4'd1, 4'd0, 4'd0);
    step("dep.t0", 1'b0, 24'h0, 24'h0, 1'b0);
    set_issue(1'b1, 1'b0, 4'd0, 4'd1, 4'd0);
    step("dep.t1", 1'b1, 24'h0, 24'h0, 1'b0);
    set_issue(1'b0, 1'b0, 4'd0, 4'd1, 4'd0);
    step("dep.t2", 1'b0, 24'h0, 24'h0, 1'b0);
    set_issue(1'b1, 1'b0, 4'd0, 4'd1, 4'd0);
    set_wb(1'b1, 4'd1, 24'h00000A);
    step("dep.t3", !BYP, BYP ? 24'h00000A : 24'h0, 24'h0, 1'b0);
    set_wb(1'b0, 4'd0, 24'h0);
    step("dep.t4", 1'b0, 24'h00000A, 24'h0, 1'b0);

    // Register 0 ignores writes and raises no error.
    set_issue(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    set_wb(1'b1, 4'd0, 24'h123456);
    step("r0.wr", 1'b0, 24'h0, 24'h0, 1'b0);
    set_wb(1'b0, 4'd0, 24'h0);
    set_issue(1'b1, 1'b0, 4'd0, 4'd0, 4'd1);
    step("r0.rd", 1'b0, 24'h0, 24'h00000A, 1'b0);

    // Saturate R4 at three outstanding writes.
    set_issue(1'b1, 1'b1, 4'd4, 4'd0, 4'd0);
    step("sat.i1", 1'b0, 24'h0, 24'h0, 1'b0);
    step("sat.i2", 1'b0, 24'h0, 24'h0, 1'b0);
    step("sat.i3", 1'b0, 24'h0, 24'h0, 1'b0);
    step("sat.i4", 1'b1, 24'h0, 24'h0, 1'b0);
    set_wb(1'b1, 4'd4, 24'h000044);
    step("sat.i4wb", 1'b1, 24'h0, 24'h0, 1'b0);
    set_wb(1'b0, 4'd0, 24'h0);
    step("sat.i4ok", 1'b0, 24'h0, 24'h0, 1'b0);
    set_issue(1'b1, 1'b0, 4'd0, 4'd0, 4'd4);
    step("sat.srcb", 1'b1, 24'h0, 24'h000044, 1'b0);

    // Same-cycle issue and write-back to R2 keep pend[2] at 1.
    set_issue(1'b1, 1'b1, 4'd2, 4'd0, 4'd0);
    step("same.i", 1'b0, 24'h0, 24'h0, 1'b0);
    set_wb(1'b1, 4'd2, 24'h000222);
    step("same.iwb", 1'b0, 24'h0, 24'h0, 1'b0);
    set_wb(1'b0, 4'd0, 24'h0);
    set_issue(1'b1, 1'b0, 4'd0, 4'd2, 4'd0);
    step("same.hold", 1'b1, 24'h000222, 24'h0, 1'b0);
    set_wb(1'b1, 4'd2, 24'h000333);
    step("same.wb2", !BYP, BYP ? 24'h000333 : 24'h000222, 24'h0, 1'b0);
    set_wb(1'b0, 4'd0, 24'h0);
    step("same.free", 1'b0, 24'h000333, 24'h0, 1'b0);

    // Spurious write-back to R5 sets the sticky error.
    set_issue(1'b0, 1'b0, 4'd0, 4'd5, 4'd0);
    set_wb(1'b1, 4'd5, 24'd7);
    step("spur.wb", 1'b0, BYP ? 24'd7 : 24'd0, 24'h0, 1'b0);
    set_wb(1'b0, 4'd0, 24'h0);
    step("spur.set", 1'b0, 24'd7, 24'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step("spur.hold", 1'b0, 24'd7, 24'h0, 1'b1);
    end

    // Mid-operation reset clears data, pending counts and the error.
    set_issue(1'b1, 1'b0, 4'd0, 4'd5, 4'd4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("rst2", 1'b0, 24'h0, 24'h0, 1'b0);

    if (sb_q.size() != 0) check_val("queue.drain", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
